cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 4: cycles the RAM block output is held stable before capture; legal range 1..15.
REQ-002 The block SHALL have parameter INDEX_BITS, default 8: cache index width, giving 256 lines of 4 words each.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cpu_req  input  1  CPU read request, sampled in IDLE only.
REQ-006 cpu_addr  input  15  CPU word address: tag [14:10], index [9:2], offset [1:0].
REQ-007 cpu_rdata  output  32  read data, valid while cpu_ready=1.
REQ-008 cpu_ready  output  1  one-cycle completion pulse.
REQ-009 cpu_busy  output  1  high in every state except IDLE.
REQ-010 mem_addr  output  15  drives the RAM Address port; always block-aligned ([1:0]=00).
REQ-011 mem_data0..mem_data3  input  32 each  the four words of the addressed RAM block.
REQ-012 hit_count  output  16  number of hits since reset.
REQ-013 access_count  output  16  number of completed accesses since reset.

Function
REQ-014 The FSM SHALL have states IDLE, LOOKUP, MISS_WAIT, FILL and RESPOND.
REQ-015 In IDLE, cpu_req=1 at an edge SHALL latch cpu_addr into addr_q and move the FSM to LOOKUP.
REQ-016 In LOOKUP, a hit is valid[idx] && tag[idx]==addr_q[14:10].
- On a hit, the controller SHALL register cpu_rdata=data[idx][offset], pulse cpu_ready, and return to IDLE.
REQ-017 On a miss in LOOKUP, the controller SHALL:
- set mem_addr={addr_q[14:2],2'b00};
- load wait counter with MEM_LATENCY-1;
- go to MISS_WAIT.
REQ-018 MISS_WAIT SHALL decrement the counter each cycle and go to FILL after the cycle in which the counter is 0, i.e. MEM_LATENCY cycles in total.
REQ-019 FILL (one cycle) SHALL:
- write mem_data0..3 into data[idx] words 0..3;
- write tag[idx]=addr_q[14:10] and set valid[idx]=1;
- go to RESPOND.
REQ-020 RESPOND SHALL present the refilled word selected by offset on cpu_rdata, pulse cpu_ready, and return to IDLE.
REQ-021 Latency, counted from the edge sampling cpu_req:
- hit: cpu_ready high in cycle 2;
- miss: cpu_ready high in cycle 3+MEM_LATENCY.
REQ-022 cpu_req while cpu_busy=1 SHALL be ignored and not queued.
- cpu_req held high continuously SHALL start a new access in the cycle immediately after cpu_ready.
REQ-023 A miss to an occupied index SHALL replace the line (direct-mapped, no write-back: the block is read-only).
REQ-024 mem_addr SHALL hold its last value outside MISS_WAIT/FILL.
REQ-025 cpu_ready SHALL be high in exactly one cycle per access; cpu_rdata SHALL hold its value until the next completion.
REQ-026 access_count SHALL increment on every cpu_ready; hit_count SHALL increment on cpu_ready following a hit.
- Both counters SHALL saturate at 16'hFFFF.

Reset
REQ-027 While rst=0, the block SHALL hold:
- FSM in IDLE;
- all valid bits cleared;
- counters, cpu_rdata, cpu_ready, mem_addr and wait counter at 0.
REQ-028 Reset during MISS_WAIT or FILL SHALL abort the access: no line written, no cpu_ready issued.
REQ-029 Tag and data arrays need not be reset; valid bits gate them.

Structure
REQ-030 Package cache_pkg SHALL hold:
- the state enum;
- TAG_BITS=5, OFFSET_BITS=2, ADDR_BITS=15, WORD_BITS=32.
REQ-031 Tag/valid/data storage SHALL be a sub-module cache_array:
- combinational read by index;
- synchronous write;
- asynchronous valid clear on reset.

Verification
REQ-032 Cold miss: reset, then a read of 15'h0005 with RAM word 5=32'hA5A5_0005.
- cpu_ready in cycle 7 (MEM_LATENCY=4), cpu_rdata=32'hA5A5_0005, mem_addr=15'h0004, hit_count=0, access_count=1.
REQ-033 Hit after fill: read 15'h0006 after REQ-032.
- cpu_ready in cycle 2, data = RAM word 6, hit_count=1, mem_addr unchanged.
REQ-034 Conflict: read 15'h0405, same index as 15'h0005, then read 15'h0005.
- Both miss, hit_count unchanged, access_count +2.
REQ-035 Busy drop: pulse cpu_req for addr 15'h0100 during MISS_WAIT.
- No extra access; access_count +1 only.
REQ-036 Reset mid-miss: assert rst in MISS_WAIT.
- No cpu_ready; a subsequent read of the same address misses.
REQ-037 Saturation: force 65536 hits.
- hit_count=access_count=16'hFFFF, with no wrap to 0.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths and FSM state encoding for the read-only cache controller
package cache_pkg;
   localparam int TAG_BITS    = 5;
   localparam int OFFSET_BITS = 2;
   localparam int ADDR_BITS   = 15;
   localparam int WORD_BITS   = 32;
   typedef enum logic [2:0] {IDLE, LOOKUP, MISS_WAIT, FILL, RESPOND} state_e;
endpackage

// File: rtl/cache_array.sv
// cache_array: direct-mapped tag/valid/data store, 4 words per line
//   clk_i, rst_ni : clock, async active-low reset (clears valid bits only)
//   idx_i         : line index for both read and write
//   we_i          : write tag_i/data_i into line idx_i and mark it valid
//   valid_o, tag_o, data_o : combinational read of line idx_i
module cache_array
   import cache_pkg::*;
#(
   parameter int INDEX_BITS = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [INDEX_BITS-1:0]     idx_i,
   input  logic                      we_i,
   input  logic [TAG_BITS-1:0]       tag_i,
   input  logic [3:0][WORD_BITS-1:0] data_i,
   output logic                      valid_o,
   output logic [TAG_BITS-1:0]       tag_o,
   output logic [3:0][WORD_BITS-1:0] data_o
);
   localparam int LINES = 1 << INDEX_BITS;
   logic [LINES-1:0]          valid_q;
   logic [TAG_BITS-1:0]       tag_q  [LINES];
   logic [3:0][WORD_BITS-1:0] data_q [LINES];
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) valid_q <= '0;
      else if (we_i) valid_q[idx_i] <= 1'b1;
   // tag/data are not reset: the valid bits gate them
   always_ff @(posedge clk_i)
      if (we_i) begin
         tag_q[idx_i]  <= tag_i;
         data_q[idx_i] <= data_i;
      end
   assign valid_o = valid_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign data_o  = data_q[idx_i];
endmodule

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped read-only cache in front of a fixed-latency RAM block
//   clk_i, rst_ni          : clock, async active-low reset
//   cpu_req_i, cpu_addr_i  : read request (accepted when idle) and word address
//   cpu_rdata_o, cpu_ready_o, cpu_busy_o : registered read data, completion pulse, busy
//   mem_addr_o             : block-aligned RAM address, held between misses
//   mem_data0_i..3_i       : the four words of the addressed RAM block
//   hit_count_o, access_count_o : saturating statistics counters
module cache_controller
   import cache_pkg::*;
#(
   parameter int MEM_LATENCY = 4,
   parameter int INDEX_BITS  = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cpu_req_i,
   input  logic [ADDR_BITS-1:0] cpu_addr_i,
   output logic [WORD_BITS-1:0] cpu_rdata_o,
   output logic                 cpu_ready_o,
   output logic                 cpu_busy_o,
   output logic [ADDR_BITS-1:0] mem_addr_o,
   input  logic [WORD_BITS-1:0] mem_data0_i,
   input  logic [WORD_BITS-1:0] mem_data1_i,
   input  logic [WORD_BITS-1:0] mem_data2_i,
   input  logic [WORD_BITS-1:0] mem_data3_i,
   output logic [15:0]          hit_count_o,
   output logic [15:0]          access_count_o
);
   state_e                    state_q, state_d;
   logic [ADDR_BITS-1:0]      addr_q, addr_d, maddr_q, maddr_d;
   logic [WORD_BITS-1:0]      rdata_q, rdata_d;
   logic                      ready_q, ready_d;
   logic [3:0]                cnt_q, cnt_d;
   logic [15:0]               hit_cnt_q, hit_cnt_d, acc_cnt_q, acc_cnt_d;
   logic                      line_valid, hit, we;
   logic [TAG_BITS-1:0]       line_tag, tag;
   logic [3:0][WORD_BITS-1:0] line_data, fill_data;
   logic [INDEX_BITS-1:0]     idx;
   logic [OFFSET_BITS-1:0]    off;
   assign tag       = addr_q[ADDR_BITS-1 -: TAG_BITS];
   assign idx       = addr_q[OFFSET_BITS +: INDEX_BITS];
   assign off       = addr_q[OFFSET_BITS-1:0];
   assign fill_data = {mem_data3_i, mem_data2_i, mem_data1_i, mem_data0_i};
   assign hit       = line_valid && line_tag == tag;
   cache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .idx_i   (idx),
      .we_i    (we),
      .tag_i   (tag),
      .data_i  (fill_data),
      .valid_o (line_valid),
      .tag_o   (line_tag),
      .data_o  (line_data)
   );
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      maddr_d = maddr_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      ready_d = 1'b0;
      we      = 1'b0;
      case (state_q)
         // RESPOND is the completion cycle of a miss; accepting here lets a held
         // cpu_req start its next access right after cpu_ready, as after a hit
         IDLE, RESPOND: begin
            state_d = cpu_req_i ? LOOKUP : IDLE;
            addr_d  = cpu_req_i ? cpu_addr_i : addr_q;
         end
         LOOKUP: begin
            state_d = hit ? IDLE : MISS_WAIT;
            rdata_d = hit ? line_data[off] : rdata_q;
            ready_d = hit;
            maddr_d = hit ? maddr_q : {addr_q[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            cnt_d   = hit ? cnt_q : 4'(MEM_LATENCY - 1);
         end
         MISS_WAIT: begin
            state_d = cnt_q == 4'd0 ? FILL : MISS_WAIT;
            cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
         end
         // line write and the registered response happen on the same edge,
         // so cpu_ready is visible during RESPOND
         FILL: begin
            we      = 1'b1;
            rdata_d = fill_data[off];
            ready_d = 1'b1;
            state_d = RESPOND;
         end
         default: state_d = IDLE;
      endcase
   end
   assign hit_cnt_d = hit_cnt_q + 16'(ready_d && state_q == LOOKUP && hit_cnt_q != 16'hFFFF);
   assign acc_cnt_d = acc_cnt_q + 16'(ready_d && acc_cnt_q != 16'hFFFF);
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         maddr_q   <= '0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         cnt_q     <= '0;
         hit_cnt_q <= '0;
         acc_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         maddr_q   <= maddr_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         cnt_q     <= cnt_d;
         hit_cnt_q <= hit_cnt_d;
         acc_cnt_q <= acc_cnt_d;
      end
   assign cpu_rdata_o    = rdata_q;
   assign cpu_ready_o    = ready_q;
   assign cpu_busy_o     = state_q != IDLE;
   assign mem_addr_o     = maddr_q;
   assign hit_count_o    = hit_cnt_q;
   assign access_count_o = acc_cnt_q;
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: scoreboard bench with a behavioural direct-mapped cache model
module tb_cache_controller;
   localparam int LAT = 4;
   logic        clk_i = 1'b0, rst_ni = 1'b0, cpu_req_i = 1'b0;
   logic [14:0] cpu_addr_i = '0;
   logic [31:0] cpu_rdata_o, mem_data0_i, mem_data1_i, mem_data2_i, mem_data3_i;
   logic        cpu_ready_o, cpu_busy_o;
   logic [14:0] mem_addr_o;
   logic [15:0] hit_count_o, access_count_o;
   int tests = 0, fails = 0, cyc = 0;
   typedef struct {
      int          issued;
      bit          hit;
      logic [31:0] data;
      logic [15:0] hits;
      logic [15:0] acc;
      logic [14:0] maddr;
   } exp_t;
   exp_t        q[$];
   logic [4:0]  m_tag [int];
   logic [15:0] m_hits = '0, m_acc = '0;
   logic [14:0] m_maddr = '0;

   function automatic logic [31:0] ram(input logic [14:0] a);
      return {16'hA5A5, 1'b0, a};
   endfunction

   assign mem_data0_i = ram(mem_addr_o);
   assign mem_data1_i = ram(mem_addr_o + 15'd1);
   assign mem_data2_i = ram(mem_addr_o + 15'd2);
   assign mem_data3_i = ram(mem_addr_o + 15'd3);

   cache_controller #(.MEM_LATENCY(LAT), .INDEX_BITS(8)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .cpu_req_i      (cpu_req_i),
      .cpu_addr_i     (cpu_addr_i),
      .cpu_rdata_o    (cpu_rdata_o),
      .cpu_ready_o    (cpu_ready_o),
      .cpu_busy_o     (cpu_busy_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data0_i    (mem_data0_i),
      .mem_data1_i    (mem_data1_i),
      .mem_data2_i    (mem_data2_i),
      .mem_data3_i    (mem_data3_i),
      .hit_count_o    (hit_count_o),
      .access_count_o (access_count_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every completion pulse is matched against the oldest expectation
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_ni && cpu_ready_o) begin
         if (q.size() == 0) check("unexpected_ready", {31'b0, cpu_ready_o}, 32'd0);
         else begin
            e = q.pop_front();
            check("rdata", cpu_rdata_o, e.data);
            check("latency", cyc - e.issued, e.hit ? 32'd2 : 32'(3 + LAT));
            check("hit_count", {16'b0, hit_count_o}, {16'b0, e.hits});
            check("access_count", {16'b0, access_count_o}, {16'b0, e.acc});
            check("mem_addr", {17'b0, mem_addr_o}, {17'b0, e.maddr});
         end
      end
   end

   // called on a falling edge; the request is sampled by the following rising edge
   task automatic do_read(input logic [14:0] a);
      int n = 0;
      int idx;
      bit h;
      while (cpu_busy_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      check("busy_wait", {31'b0, cpu_busy_o}, 32'd0);
      idx = int'(a[9:2]);
      h = m_tag.exists(idx) && m_tag[idx] == a[14:10];
      if (!h) begin
         m_tag[idx] = a[14:10];
         m_maddr = a & 15'h7FFC;
      end
      if (h && m_hits != 16'hFFFF) m_hits++;
      if (m_acc != 16'hFFFF) m_acc++;
      q.push_back('{cyc, h, ram(a), m_hits, m_acc, m_maddr});
      cpu_req_i  = 1'b1;
      cpu_addr_i = a;
      @(negedge clk_i);
      cpu_req_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      check("drain", q.size(), 32'd0);
      q.delete();
      @(negedge clk_i);
   endtask

   task automatic check_reset_values();
      check("rst_rdata", cpu_rdata_o, 32'd0);
      check("rst_ready", {31'b0, cpu_ready_o}, 32'd0);
      check("rst_busy", {31'b0, cpu_busy_o}, 32'd0);
      check("rst_mem_addr", {17'b0, mem_addr_o}, 32'd0);
      check("rst_hits", {16'b0, hit_count_o}, 32'd0);
      check("rst_acc", {16'b0, access_count_o}, 32'd0);
   endtask

   task automatic model_reset();
      q.delete();
      m_tag.delete();
      m_hits  = '0;
      m_acc   = '0;
      m_maddr = '0;
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      check_reset_values();
      rst_ni = 1'b1;
      @(negedge clk_i);
      // cold miss, hit in the same line, then a conflicting tag on index 1
      do_read(15'h0005);
      drain();
      do_read(15'h0006);
      drain();
      do_read(15'h0405);
      do_read(15'h0005);
      drain();
      // request pulse while busy in MISS_WAIT must be dropped
      do_read(15'h0805);
      @(negedge clk_i);
      cpu_req_i  = 1'b1;
      cpu_addr_i = 15'h0100;
      @(negedge clk_i);
      cpu_req_i = 1'b0;
      drain();
      // reset in the middle of a miss aborts it and invalidates the cache
      do_read(15'h0A0A);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b0;
      model_reset();
      @(negedge clk_i);
      check_reset_values();
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      do_read(15'h0A0A);
      drain();
      // random reads over a small tag/index pool, gaps of 0..2 cycles
      for (int i = 0; i < 300; i++) begin
         do_read({5'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3))});
         repeat ($urandom_range(0, 2)) @(negedge clk_i);
      end
      drain();
      // saturation: preload both counters near the top, then keep completing accesses
      force dut.hit_cnt_q = 16'hFFFD;
      force dut.acc_cnt_q = 16'hFFFD;
      @(negedge clk_i);
      release dut.hit_cnt_q;
      release dut.acc_cnt_q;
      m_hits = 16'hFFFD;
      m_acc  = 16'hFFFD;
      repeat (6) do_read(15'h1234);
      drain();
      check("sat_hits", {16'b0, hit_count_o}, 32'h0000FFFF);
      check("sat_acc", {16'b0, access_count_o}, 32'h0000FFFF);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
      $fatal(1);
   end
endmodule
